// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared present type codes, scheduler states and type mapping
// Contents:
//   present_type_t     3-bit present type code (LIFE..BONUS), shared with presentsController
//   NUM_PRESENT_TYPES  number of valid type codes
//   sched_state_t      scheduler state register type, ST_* state constants
//   LFSR_MASK          Galois feedback mask for the game's 16-bit LFSRs
//   map_type()         folds a 3-bit raw roll onto the five valid type codes
package present_pkg;

   typedef enum logic [2:0] {
      PT_LIFE        = 3'd0,
      PT_SHIELD      = 3'd1,
      PT_FREEZE      = 3'd2,
      PT_DOUBLE_ROPE = 3'd3,
      PT_BONUS       = 3'd4
   } present_type_t;

   localparam int NUM_PRESENT_TYPES = 5;

   typedef logic [2:0] sched_state_t;
   localparam sched_state_t ST_IDLE     = 3'd0;
   localparam sched_state_t ST_ARMED    = 3'd1;
   localparam sched_state_t ST_DECIDE   = 3'd2;
   localparam sched_state_t ST_DROP     = 3'd3;
   localparam sched_state_t ST_COOLDOWN = 3'd4;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   // Raw values 5..7 wrap back to 0..2, so LIFE/SHIELD/FREEZE are slightly more likely.
   function automatic present_type_t map_type(input logic [2:0] traw);
      if (traw < 3'(NUM_PRESENT_TYPES))
         return present_type_t'(traw);
      else
         return present_type_t'(traw - 3'(NUM_PRESENT_TYPES));
   endfunction

endpackage

// File: rtl/present_drop_scheduler_if.sv
// rtl/present_drop_scheduler_if.sv - ball-pop in / present-drop out bundle
// Signals:
//   ball_pop, ball_pop_x, ball_pop_y         pop event from ball/rope collision logic
//   dropPresent, nxt_present, drop_x, drop_y drop request to the presents controller
// Modports:
//   master  scheduler side (consumes pops, issues drops)
//   slave   environment side (issues pops, consumes drops)
interface present_drop_scheduler_if import present_pkg::*; #(
   parameter int XW = 11
);
   logic          ball_pop;
   logic [XW-1:0] ball_pop_x;
   logic [XW-1:0] ball_pop_y;
   logic          dropPresent;
   present_type_t nxt_present;
   logic [XW-1:0] drop_x;
   logic [XW-1:0] drop_y;

   modport master (
      input  ball_pop, ball_pop_x, ball_pop_y,
      output dropPresent, nxt_present, drop_x, drop_y
   );

   modport slave (
      output ball_pop, ball_pop_x, ball_pop_y,
      input  dropPresent, nxt_present, drop_x, drop_y
   );
endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR
// Ports:
//   clk     system clock
//   resetN  asynchronous active-low reset, loads SEED
//   q       current LFSR state, advances every clock
// SEED must be nonzero or the register locks at zero.
module lfsr16 import present_pkg::*; #(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter logic [15:0] MASK = LFSR_MASK
) (
   input  logic        clk,
   input  logic        resetN,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         q <= SEED;
      else
         q <= {1'b0, q[15:1]} ^ (q[0] ? MASK : 16'h0000);
   end

endmodule

// File: rtl/present_drop_scheduler.sv
// rtl/present_drop_scheduler.sv - decides when and which present drops on a ball pop
// Ports:
//   clk, resetN    system clock, asynchronous active-low reset
//   enable         high while a level runs; low forces IDLE from the next edge
//   secClk         one-cycle pulse per second, paces the cooldown
//   slots_active   presents controller occupancy; 3'b111 means no free slot
//   cooldown_busy  high while in COOLDOWN
//   drop_count     drops issued this level, saturating at 255
//   bus            pop inputs and drop request outputs (master side)
module present_drop_scheduler import present_pkg::*; #(
   parameter int unsigned COOLDOWN_SEC = 3,
   parameter int unsigned DROP_THRESH  = 64,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          XW           = 11
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       enable,
   input  logic       secClk,
   input  logic [2:0] slots_active,
   output logic       cooldown_busy,
   output logic [7:0] drop_count,
   present_drop_scheduler_if.master bus
);

   localparam logic [3:0] CD_INIT = 4'(COOLDOWN_SEC);
   localparam logic [8:0] THRESH  = 9'(DROP_THRESH);

   logic [15:0]   lfsr_w;
   logic          lfsr_unused;

   sched_state_t  state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;

   // Pop snapshot taken in ARMED, consumed by DECIDE/DROP.
   logic [7:0]    roll_q;
   present_type_t type_q;
   logic [XW-1:0] px_q, py_q;

   logic          drop_q;
   present_type_t nxt_q;
   logic [XW-1:0] dx_q, dy_q;
   logic          busy_q;
   logic [7:0]    dcnt_q;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .resetN (resetN),
      .q      (lfsr_w)
   );

   assign lfsr_unused = ^lfsr_w[15:11];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // level-start grace period
               state_d = ST_COOLDOWN;
               cnt_d   = CD_INIT;
            end
            ST_COOLDOWN: begin
               // exit on zero regardless of secClk, so the count never wraps
               if (cnt_q == 4'd0)
                  state_d = ST_ARMED;
               else if (secClk)
                  cnt_d = cnt_q - 4'd1;
            end
            ST_ARMED: begin
               if (bus.ball_pop)
                  state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
               if (({1'b0, roll_q} < THRESH) && (slots_active != 3'b111))
                  state_d = ST_DROP;
               else
                  state_d = ST_ARMED;
            end
            ST_DROP: begin
               state_d = ST_COOLDOWN;
               cnt_d   = CD_INIT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         roll_q  <= 8'd0;
         type_q  <= PT_LIFE;
         px_q    <= '0;
         py_q    <= '0;
         drop_q  <= 1'b0;
         nxt_q   <= PT_LIFE;
         dx_q    <= '0;
         dy_q    <= '0;
         busy_q  <= 1'b0;
         dcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;

         if (state_q == ST_ARMED && bus.ball_pop) begin
            roll_q <= lfsr_w[7:0];
            type_q <= map_type(lfsr_w[10:8]);
            px_q   <= bus.ball_pop_x;
            py_q   <= bus.ball_pop_y;
         end

         busy_q <= (state_d == ST_COOLDOWN);
         // DROP lasts one cycle and always leaves, so the pulse cannot repeat.
         drop_q <= enable && (state_q == ST_DROP);

         if (!enable) begin
            dcnt_q <= 8'd0;
            nxt_q  <= PT_LIFE;
            dx_q   <= '0;
            dy_q   <= '0;
         end else if (state_q == ST_DROP) begin
            nxt_q <= type_q;
            dx_q  <= px_q;
            dy_q  <= py_q;
            if (dcnt_q != 8'hFF)
               dcnt_q <= dcnt_q + 8'd1;
         end
      end
   end

   assign bus.dropPresent = drop_q;
   assign bus.nxt_present = nxt_q;
   assign bus.drop_x      = dx_q;
   assign bus.drop_y      = dy_q;
   assign cooldown_busy   = busy_q;
   assign drop_count      = dcnt_q;

endmodule

// File: tb/tb_present_drop_scheduler.sv
// tb/tb_present_drop_scheduler.sv - self-checking bench for present_drop_scheduler
`timescale 1ns/1ps
module tb_present_drop_scheduler;
   import present_pkg::*;

   localparam int XW = 11;
   localparam int NI = 4;
   // instance 0: cd3/th256, 1: cd0/th256, 2: cd1/th0, 3: cd3/th64
   localparam bit [15:0] CDS = {4'd3, 4'd1, 4'd0, 4'd3};
   localparam bit [35:0] THS = {9'd64, 9'd0, 9'd256, 9'd256};

   logic          clk;
   logic          resetN;
   logic          enable;
   logic          sec;
   logic          pop;
   logic [XW-1:0] px, py;
   logic [2:0]    slots;

   logic          dp_w   [NI];
   logic [2:0]    nxt_w  [NI];
   logic [XW-1:0] dx_w   [NI];
   logic [XW-1:0] dy_w   [NI];
   logic          busy_w [NI];
   logic [7:0]    cnt_w  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      present_drop_scheduler_if #(.XW(XW)) bus ();
      assign bus.ball_pop   = pop;
      assign bus.ball_pop_x = px;
      assign bus.ball_pop_y = py;

      present_drop_scheduler #(
         .COOLDOWN_SEC (int'(CDS[g*4 +: 4])),
         .DROP_THRESH  (int'(THS[g*9 +: 9])),
         .LFSR_SEED    (16'hACE1),
         .XW           (XW)
      ) u_dut (
         .clk           (clk),
         .resetN        (resetN),
         .enable        (enable),
         .secClk        (sec),
         .slots_active  (slots),
         .cooldown_busy (busy_w[g]),
         .drop_count    (cnt_w[g]),
         .bus           (bus)
      );

      assign dp_w[g]  = bus.dropPresent;
      assign nxt_w[g] = bus.nxt_present;
      assign dx_w[g]  = bus.drop_x;
      assign dy_w[g]  = bus.drop_y;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_fail = 0;
   int drops2 = 0;
   bit prev_dp [NI];

   // ---------------- reference model ----------------
   bit [15:0] lfsr_m;
   bit m_off  [NI];
   int m_cool [NI];   // -1: not cooling, else seconds left
   int m_pend [NI];   // 0: none, 1: awaiting verdict, 2: about to drop
   int m_roll [NI];
   int m_type [NI];
   int m_px   [NI];
   int m_py   [NI];
   bit e_dp   [NI];
   bit e_busy [NI];
   int e_cnt  [NI];
   int e_type [NI];
   int e_x    [NI];
   int e_y    [NI];

   function automatic int cd_of(input int i);
      return int'(CDS[i*4 +: 4]);
   endfunction

   function automatic int th_of(input int i);
      return int'(THS[i*9 +: 9]);
   endfunction

   function automatic bit [15:0] lfsr_next(input bit [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lfsr_m <= 16'hACE1;
         for (int i = 0; i < NI; i++) begin
            m_off[i] <= 1'b1; m_cool[i] <= -1; m_pend[i] <= 0;
            e_dp[i] <= 1'b0; e_busy[i] <= 1'b0; e_cnt[i] <= 0;
            e_type[i] <= 0; e_x[i] <= 0; e_y[i] <= 0;
         end
      end else begin
         lfsr_m <= lfsr_next(lfsr_m);
         for (int i = 0; i < NI; i++) begin
            e_dp[i] <= 1'b0;
            if (!enable) begin
               m_off[i] <= 1'b1; m_cool[i] <= -1; m_pend[i] <= 0;
               e_busy[i] <= 1'b0; e_cnt[i] <= 0;
               e_type[i] <= 0; e_x[i] <= 0; e_y[i] <= 0;
            end else if (m_off[i]) begin
               m_off[i] <= 1'b0; m_cool[i] <= cd_of(i); e_busy[i] <= 1'b1;
            end else if (m_pend[i] == 2) begin
               e_dp[i] <= 1'b1;
               e_type[i] <= m_type[i]; e_x[i] <= m_px[i]; e_y[i] <= m_py[i];
               e_cnt[i] <= (e_cnt[i] < 255) ? e_cnt[i] + 1 : 255;
               m_pend[i] <= 0; m_cool[i] <= cd_of(i); e_busy[i] <= 1'b1;
            end else if (m_pend[i] == 1) begin
               m_pend[i] <= (m_roll[i] < th_of(i) && slots != 3'b111) ? 2 : 0;
            end else if (m_cool[i] >= 0) begin
               if (m_cool[i] == 0) begin
                  m_cool[i] <= -1; e_busy[i] <= 1'b0;
               end else if (sec) begin
                  m_cool[i] <= m_cool[i] - 1;
               end
            end else if (pop) begin
               m_pend[i] <= 1;
               m_roll[i] <= int'(lfsr_m[7:0]);
               m_type[i] <= int'(lfsr_m[10:8]) % 5;
               m_px[i]   <= int'(px);
               m_py[i]   <= int'(py);
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [34:0] act, exp;
      for (int i = 0; i < NI; i++) begin
         act = {dp_w[i], busy_w[i], cnt_w[i], nxt_w[i], dx_w[i], dy_w[i]};
         exp = {e_dp[i], e_busy[i], 8'(e_cnt[i]), 3'(e_type[i]), XW'(e_x[i]), XW'(e_y[i])};
         n_chk++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL model[%0d] t=%0t actual={dp,busy,cnt,type,x,y}=%h expected=%h",
                     i, $time, act, exp);
         end
         n_chk++;
         if (dp_w[i] && prev_dp[i]) begin
            n_fail++;
            $display("FAIL dp_consecutive[%0d] t=%0t actual=2 high cycles expected=1", i, $time);
         end
         prev_dp[i] = dp_w[i];
      end
      if (dp_w[2]) drops2++;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         model_check();
      end
   endtask

   task automatic wait_armed();
      int k = 0;
      while (!(m_off[0] == 1'b0 && m_cool[0] < 0 && m_pend[0] == 0) && k < 200) begin
         sec = (k % 3 == 2);
         cyc(1);
         k++;
      end
      sec = 1'b0;
      if (k >= 200) chk("wait_armed_timeout", k, 0);
   endtask

   typedef struct {
      int       x;
      int       y;
      bit [2:0] slots;
      bit       exp_drop;
   } vec_t;

   vec_t tbl [6];
   int   tr  [3];
   int   te  [3];
   int   exp_cnt;

   initial begin
      tbl[0] = '{100,  50,   3'b000, 1'b1};
      tbl[1] = '{7,    2047, 3'b111, 1'b0};
      tbl[2] = '{2047, 0,    3'b011, 1'b1};
      tbl[3] = '{0,    0,    3'b110, 1'b1};
      tbl[4] = '{1234, 567,  3'b111, 1'b0};
      tbl[5] = '{1,    1,    3'b101, 1'b1};
      tr = '{6, 7, 5};
      te = '{1, 2, 0};
      exp_cnt = 0;

      resetN = 1'b0; enable = 1'b0; sec = 1'b0; pop = 1'b0;
      px = '0; py = '0; slots = 3'b000;
      cyc(2);
      chk("reset_dp",   int'(dp_w[0]),   0);
      chk("reset_busy", int'(busy_w[0]), 0);
      chk("reset_cnt",  int'(cnt_w[0]),  0);
      resetN = 1'b1;
      cyc(2);

      // level start grace: busy until the 3rd secClk, ARMED one cycle later
      enable = 1'b1;
      cyc(1);
      chk("grace_busy_start", int'(busy_w[0]), 1);
      for (int s = 1; s <= 3; s++) begin
         sec = 1'b1;
         cyc(1);
         sec = 1'b0;
         chk($sformatf("grace_busy_sec%0d", s), int'(busy_w[0]), 1);
         if (s < 3) begin
            cyc(1);
            chk($sformatf("grace_busy_gap%0d", s), int'(busy_w[0]), 1);
         end
      end
      cyc(1);
      chk("grace_armed", int'(busy_w[0]), 0);
      chk("grace_cnt", int'(cnt_w[0]), 0);

      // table-driven pops on instance 0 (always-roll threshold)
      for (int i = 0; i < 6; i++) begin
         wait_armed();
         slots = tbl[i].slots; px = XW'(tbl[i].x); py = XW'(tbl[i].y);
         pop = 1'b1;
         cyc(1);
         pop = 1'b0;
         cyc(1);
         chk($sformatf("tbl%0d_early", i), int'(dp_w[0]), 0);
         cyc(1);
         chk($sformatf("tbl%0d_drop", i), int'(dp_w[0]), int'(tbl[i].exp_drop));
         if (tbl[i].exp_drop) begin
            exp_cnt++;
            chk($sformatf("tbl%0d_x", i), int'(dx_w[0]), tbl[i].x);
            chk($sformatf("tbl%0d_y", i), int'(dy_w[0]), tbl[i].y);
            chk($sformatf("tbl%0d_type_range", i), int'(nxt_w[0] < 3'd5), 1);
            chk($sformatf("tbl%0d_cnt", i), int'(cnt_w[0]), exp_cnt);
            pop = 1'b1;
            for (int k = 0; k < 5; k++) begin
               cyc(1);
               pop = 1'b0;
               chk($sformatf("tbl%0d_cooldown_pop", i), int'(dp_w[0]), 0);
            end
         end else begin
            chk($sformatf("tbl%0d_rearmed", i), int'(busy_w[0]), 0);
            chk($sformatf("tbl%0d_cnt", i), int'(cnt_w[0]), exp_cnt);
         end
      end
      slots = 3'b000;

      // pick the LFSR cycle so the raw type field is 6, 7, 5
      for (int t = 0; t < 3; t++) begin
         int k;
         wait_armed();
         k = 0;
         while (int'(lfsr_m[10:8]) != tr[t] && k < 100) begin
            cyc(1);
            k++;
         end
         if (k >= 100) chk("traw_search_timeout", k, 0);
         pop = 1'b1; px = XW'(300 + t); py = XW'(t);
         cyc(1);
         pop = 1'b0;
         cyc(2);
         exp_cnt++;
         chk($sformatf("traw%0d_drop", tr[t]), int'(dp_w[0]), 1);
         chk($sformatf("traw%0d_type", tr[t]), int'(nxt_w[0]), te[t]);
      end
      chk("count_after_types", int'(cnt_w[0]), exp_cnt);

      // enable falls while DECIDE is pending
      wait_armed();
      pop = 1'b1;
      cyc(1);
      pop = 1'b0; enable = 1'b0;
      cyc(1);
      chk("abort_dp", int'(dp_w[0]), 0);
      chk("abort_busy", int'(busy_w[0]), 0);
      chk("abort_cnt", int'(cnt_w[0]), 0);
      cyc(1);
      chk("abort_dp_late", int'(dp_w[0]), 0);
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         chk("regrace_busy", int'(busy_w[0]), 1);
      end
      wait_armed();

      // random traffic against the model
      for (int k = 0; k < 2000; k++) begin
         pop    = 1'($urandom_range(0, 1));
         px     = XW'($urandom);
         py     = XW'($urandom);
         slots  = 3'($urandom_range(0, 7));
         sec    = ($urandom_range(0, 3) == 0);
         enable = ($urandom_range(0, 149) != 0);
         cyc(1);
      end
      chk("never_threshold_drops", drops2, 0);

      // continuous pops with zero cooldown: drop_count must saturate
      enable = 1'b1; slots = 3'b000; sec = 1'b0; pop = 1'b1;
      cyc(1300);
      pop = 1'b0;
      chk("saturate_cnt", int'(cnt_w[1]), 255);
      cyc(2);

      // asynchronous reset mid-run
      #2 resetN = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("async_rst_dp%0d", i), int'(dp_w[i]), 0);
         chk($sformatf("async_rst_busy%0d", i), int'(busy_w[i]), 0);
         chk($sformatf("async_rst_cnt%0d", i), int'(cnt_w[i]), 0);
      end
      cyc(1);
      resetN = 1'b1;
      cyc(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
